// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and pointer-code helpers shared by the write-side and
// read-side controllers of the asynchronous FIFO.
//   FIFO_ADDR_WIDTH : default address width (depth = 2**FIFO_ADDR_WIDTH)
//   FIFO_PTR_W      : pointer width, one extra wrap bit over the address
//   FIFO_DEPTH      : number of storage entries
//   bin2gray/gray2bin operate on a wide container; callers zero-extend their
//   pointer into it and truncate the result, which is exact for both codes
//   because the extra high bits are zero.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned FIFO_PTR_W      = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;
  localparam int unsigned FIFO_CONV_W     = 32;

  typedef logic [FIFO_CONV_W-1:0] fifo_conv_t;

  function automatic fifo_conv_t bin2gray(input fifo_conv_t i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic fifo_conv_t gray2bin(input fifo_conv_t i_gray);
    fifo_conv_t r_bin;
    r_bin = '0;
    for (int i = 0; i < FIFO_CONV_W; i++) begin
      r_bin[i] = ^(i_gray >> i);
    end
    return r_bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter (XOR prefix from MSB).
// Shared by the write-full and read-empty controllers.
// Ports:
//   i_gray [WIDTH-1:0] : Gray-coded input
//   o_bin  [WIDTH-1:0] : binary equivalent
module gray2bin_conv #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain pointer and flag controller of the async FIFO.
// Keeps the binary write pointer, publishes its Gray form to the pointer
// synchronizer, and derives FULL, the memory write strobe, a pessimistic fill
// level and a sticky overflow flag from the read pointer synchronized into
// this domain.
// Optional feature: define FIFO_WR_AFULL_EN to add the registered AFULL output
// (occupancy >= AFULL_THRESH).
// Ports:
//   W_CLK    : write-domain clock
//   W_RST    : asynchronous active-high reset
//   W_INC    : write request from the producer
//   wq2_rptr : Gray read pointer, already synchronized to W_CLK
//   w_ptr    : registered Gray write pointer, to the synchronizer
//   w_addr   : binary write address of the current slot
//   w_clken  : memory write enable (W_INC & ~FULL), combinational
//   FULL     : registered full flag
//   w_level  : registered occupancy, 0..2**ADDR_WIDTH
//   AFULL    : registered almost-full flag (FIFO_WR_AFULL_EN only)
//   w_ovf    : sticky overflow, set by a write attempted while full
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic [ADDR_WIDTH:0]   w_ptr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  w_clken,
  output logic                  FULL,
  output logic [ADDR_WIDTH:0]   w_level,
`ifdef FIFO_WR_AFULL_EN
  output logic                  AFULL,
`endif
  output logic                  w_ovf
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Full when the write pointer is exactly one lap ahead: in Gray code that
  // is the read pointer with its two MSBs inverted.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

  if (AFULL_THRESH < 1 || AFULL_THRESH >= DEPTH) begin : g_bad_afull_thresh
    $error("fifo_wr_ctrl: AFULL_THRESH must lie in 1..2**ADDR_WIDTH-1");
  end

  logic [PTR_W-1:0] r_wbin;
  logic [PTR_W-1:0] r_wgray;
  logic             r_full;
  logic [PTR_W-1:0] r_level;
  logic             r_ovf;

  logic             w_inc_ok;
  logic [PTR_W-1:0] w_wbin_next;
  logic [PTR_W-1:0] w_wgray_next;
  logic [PTR_W-1:0] w_rbin;
  logic             w_full_next;
  logic [PTR_W-1:0] w_level_next;

  gray2bin_conv #(
    .WIDTH (PTR_W)
  ) u_rptr_conv (
    .i_gray (wq2_rptr),
    .o_bin  (w_rbin)
  );

  always_comb begin
    w_inc_ok     = W_INC & ~r_full;
    w_wbin_next  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_inc_ok};
    w_wgray_next = PTR_W'(bin2gray(fifo_conv_t'(w_wbin_next)));
    w_full_next  = (w_wgray_next == (wq2_rptr ^ FULL_MASK));
    // Modulo subtraction; reads the old rptr, so release is pessimistic.
    w_level_next = w_wbin_next - w_rbin;
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
      r_level <= w_level_next;
      // A request seen while full is dropped; remember it until reset.
      if (W_INC && r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef FIFO_WR_AFULL_EN
  localparam logic [PTR_W-1:0] AFULL_TH = PTR_W'(AFULL_THRESH);

  logic r_afull;

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      r_afull <= 1'b0;
    end else begin
      r_afull <= (w_level_next >= AFULL_TH);
    end
  end

  assign AFULL = r_afull;
`endif

  assign w_ptr   = r_wgray;
  assign w_addr  = r_wbin[ADDR_WIDTH-1:0];
  assign w_clken = w_inc_ok;
  assign FULL    = r_full;
  assign w_level = r_level;
  assign w_ovf   = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: self-checking bench for fifo_wr_ctrl. The reference model
// tracks total accepted writes and the read count as plain integers; occupancy
// is their difference and FULL means occupancy equals the depth.
module tb_fifo_wr_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int TH    = 6;

  logic          W_CLK;
  logic          W_RST;
  logic          W_INC;
  logic [AW:0]   wq2_rptr;
  logic [AW:0]   w_ptr;
  logic [AW-1:0] w_addr;
  logic          w_clken;
  logic          FULL;
  logic [AW:0]   w_level;
  logic          w_ovf;
`ifdef FIFO_WR_AFULL_EN
  logic          AFULL;
`endif

  fifo_wr_ctrl #(
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (TH)
  ) dut (
    .W_CLK    (W_CLK),
    .W_RST    (W_RST),
    .W_INC    (W_INC),
    .wq2_rptr (wq2_rptr),
    .w_ptr    (w_ptr),
    .w_addr   (w_addr),
    .w_clken  (w_clken),
    .FULL     (FULL),
    .w_level  (w_level),
`ifdef FIFO_WR_AFULL_EN
    .AFULL    (AFULL),
`endif
    .w_ovf    (w_ovf)
  );

  initial W_CLK = 1'b0;
  always #5 W_CLK = ~W_CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int m_wr    = 0;   // total accepted writes
  int m_rd    = 0;   // total reads reflected in wq2_rptr
  bit m_full  = 0;
  int m_level = 0;
  bit m_ovf   = 0;
  bit m_afull = 0;

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = (AW + 1)'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_full = 0; m_level = 0; m_ovf = 0; m_afull = 0;
  endtask

  // Set inputs shortly after an edge; rd_adv moves the synchronized rptr on.
  task automatic drive(input bit inc, input bit rd_adv);
    W_INC = inc;
    if (rd_adv) m_rd++;
    wq2_rptr = to_gray(m_rd);
    #1;
  endtask

  // Clock one edge and advance the model with the inputs present at the edge.
  task automatic clk_edge();
    bit acc;
    bit hit;
    acc = W_INC && !m_full;
    hit = W_INC && m_full;
    @(posedge W_CLK);
    if (acc) m_wr++;
    m_level = m_wr - m_rd;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= TH);
    if (hit) m_ovf = 1;
    #1;
  endtask

  task automatic do_reset();
    W_INC = 0;
    W_RST = 1;
    model_reset();
    wq2_rptr = to_gray(0);
    @(posedge W_CLK);
    #3;
    W_RST = 0;
    @(posedge W_CLK);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (w_ptr !== 4'b0000 || FULL !== 1'b0 || w_level !== 4'd0 || w_ovf !== 1'b0 ||
        w_addr !== 3'd0) begin
      $display("FAIL reset_init: ptr=%b full=%b lvl=%0d ovf=%b addr=%0d want all 0",
               w_ptr, FULL, w_level, w_ovf, w_addr);
    end else n_pass++;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0);
      clk_edge();
    end
    n_checks++;
    if (w_addr !== 3'd5 || w_ptr !== to_gray(5)) begin
      $display("FAIL reset_pre: addr=%0d ptr=%b want 5 %b", w_addr, w_ptr, to_gray(5));
    end else n_pass++;
    // Assert reset between edges: outputs must clear without a clock.
    #2;
    W_RST = 1;
    #1;
    n_checks++;
    if (w_ptr !== 4'b0000 || FULL !== 1'b0 || w_level !== 4'd0 || w_ovf !== 1'b0 ||
        w_addr !== 3'd0) begin
      $display("FAIL reset_async: ptr=%b full=%b lvl=%0d ovf=%b addr=%0d want all 0",
               w_ptr, FULL, w_level, w_ovf, w_addr);
    end else n_pass++;
    W_INC = 0;
    model_reset();
    wq2_rptr = to_gray(0);
    @(posedge W_CLK);
    #3;
    W_RST = 0;
    @(posedge W_CLK);
    #1;
    n_checks++;
    if (w_ptr !== 4'b0000 || w_addr !== 3'd0) begin
      $display("FAIL reset_release: ptr=%b addr=%0d want 0000 0", w_ptr, w_addr);
    end else n_pass++;
  endtask

  task automatic test_fill();
    logic [AW:0] exp_ptr [8];
    exp_ptr = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0);
      n_checks++;
      if (w_addr !== 3'(i) || w_clken !== 1'b1) begin
        $display("FAIL fill_addr[%0d]: addr=%0d clken=%b want %0d 1", i, w_addr, w_clken, i);
      end else n_pass++;
      clk_edge();
      n_checks++;
      if (w_ptr !== exp_ptr[i] || FULL !== m_full) begin
        $display("FAIL fill_ptr[%0d]: ptr=%b full=%b want %b %b", i, w_ptr, FULL,
                 exp_ptr[i], m_full);
      end else n_pass++;
    end
    n_checks++;
    if (FULL !== 1'b1 || w_level !== 4'd8) begin
      $display("FAIL fill_full: full=%b lvl=%0d want 1 8", FULL, w_level);
    end else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0);
      n_checks++;
      if (w_clken !== 1'b0) begin
        $display("FAIL ovf_clken[%0d]: clken=%b want 0", i, w_clken);
      end else n_pass++;
      clk_edge();
      n_checks++;
      if (w_ptr !== 4'b1100 || w_ovf !== 1'b1 || w_level !== 4'd8 || w_addr !== 3'd0) begin
        $display("FAIL ovf_hold[%0d]: ptr=%b ovf=%b lvl=%0d addr=%0d want 1100 1 8 0", i,
                 w_ptr, w_ovf, w_level, w_addr);
      end else n_pass++;
    end
    drive(0, 0);
    clk_edge();
    n_checks++;
    if (w_ovf !== 1'b1) begin
      $display("FAIL ovf_sticky: ovf=%b want 1", w_ovf);
    end else n_pass++;
  endtask

  task automatic test_release();
    drive(0, 1);
    clk_edge();
    n_checks++;
    if (FULL !== 1'b0 || w_level !== 4'd7) begin
      $display("FAIL release_flags: full=%b lvl=%0d want 0 7", FULL, w_level);
    end else n_pass++;
    drive(1, 0);
    n_checks++;
    if (w_addr !== 3'd0 || w_clken !== 1'b1) begin
      $display("FAIL release_addr: addr=%0d clken=%b want 0 1", w_addr, w_clken);
    end else n_pass++;
    clk_edge();
    n_checks++;
    if (w_ptr !== 4'b1101 || FULL !== 1'b1) begin
      $display("FAIL release_ptr: ptr=%b full=%b want 1101 1", w_ptr, FULL);
    end else n_pass++;
  endtask

  // A write offered in the same cycle the read pointer frees a slot is still
  // refused; FULL drops on that edge and the retry goes through.
  task automatic test_full_simul();
    drive(1, 1);
    n_checks++;
    if (w_clken !== 1'b0) begin
      $display("FAIL simul_reject: clken=%b want 0", w_clken);
    end else n_pass++;
    clk_edge();
    n_checks++;
    if (FULL !== 1'b0 || w_ptr !== 4'b1101) begin
      $display("FAIL simul_clear: full=%b ptr=%b want 0 1101", FULL, w_ptr);
    end else n_pass++;
    drive(1, 0);
    n_checks++;
    if (w_clken !== 1'b1 || w_addr !== 3'd1) begin
      $display("FAIL simul_retry: clken=%b addr=%0d want 1 1", w_clken, w_addr);
    end else n_pass++;
    clk_edge();
    n_checks++;
    if (FULL !== 1'b1 || w_ptr !== to_gray(10)) begin
      $display("FAIL simul_accept: full=%b ptr=%b want 1 %b", FULL, w_ptr, to_gray(10));
    end else n_pass++;
  endtask

  task automatic test_wrap();
    logic [AW:0] prev;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0);
      clk_edge();
    end
    prev = w_ptr;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1);
      clk_edge();
      n_checks++;
      if (FULL !== 1'b0 || w_level !== 4'd3 || $countones(prev ^ w_ptr) != 1 ||
          w_ptr !== to_gray(m_wr)) begin
        $display("FAIL wrap[%0d]: full=%b lvl=%0d ptr=%b prev=%b want 0 3 %b", i, FULL,
                 w_level, w_ptr, prev, to_gray(m_wr));
      end else n_pass++;
      prev = w_ptr;
    end
  endtask

`ifdef FIFO_WR_AFULL_EN
  task automatic test_afull();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0);
      clk_edge();
      n_checks++;
      if (AFULL !== (i == 5)) begin
        $display("FAIL afull[%0d]: afull=%b want %b", i, AFULL, (i == 5));
      end else n_pass++;
    end
    drive(0, 1);
    clk_edge();
    n_checks++;
    if (AFULL !== 1'b0) begin
      $display("FAIL afull_release: afull=%b want 0", AFULL);
    end else n_pass++;
  endtask
`endif

  task automatic test_random();
    bit inc;
    bit adv;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      inc = ($urandom_range(0, 99) < 60);
      adv = (m_rd < m_wr) && ($urandom_range(0, 99) < 45);
      drive(inc, adv);
      n_checks++;
      if (w_clken !== (inc && !m_full) || w_addr !== 3'(m_wr % DEPTH)) begin
        $display("FAIL rand_comb[%0d]: clken=%b addr=%0d want %b %0d", i, w_clken, w_addr,
                 (inc && !m_full), m_wr % DEPTH);
      end else n_pass++;
      clk_edge();
      n_checks++;
      if (w_ptr !== to_gray(m_wr) || FULL !== m_full || w_level !== 4'(m_level) ||
          w_ovf !== m_ovf) begin
        $display("FAIL rand_reg[%0d]: ptr=%b full=%b lvl=%0d ovf=%b want %b %b %0d %b", i,
                 w_ptr, FULL, w_level, w_ovf, to_gray(m_wr), m_full, m_level, m_ovf);
      end else n_pass++;
`ifdef FIFO_WR_AFULL_EN
      n_checks++;
      if (AFULL !== m_afull) begin
        $display("FAIL rand_afull[%0d]: afull=%b want %b", i, AFULL, m_afull);
      end else n_pass++;
`endif
    end
  endtask

  initial begin
    W_RST    = 1'b1;
    W_INC    = 1'b0;
    wq2_rptr = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_full_simul();
    test_wrap();
`ifdef FIFO_WR_AFULL_EN
    test_afull();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Write-domain pointer/flag controller for the team's asynchronous FIFO; sits directly upstream of the pointer double-flop synchronizer.
- Produces the Gray-coded write pointer that the synchronizer carries into the read domain.
- Consumes the read pointer already synchronized into the write domain and derives FULL, the memory write address/enable, and a fill level.

Parameters:
- ADDR_WIDTH, 3, FIFO address bits; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 6, almost-full threshold in entries (used only with the optional feature); legal range 1..2**ADDR_WIDTH-1.

Ports:
- W_CLK  in  1  write-domain clock
- W_RST  in  1  asynchronous, active-high reset
- W_INC  in  1  write request from producer
- wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already synchronized to W_CLK
- w_ptr  out  ADDR_WIDTH+1  registered Gray write pointer, to synchronizer
- w_addr  out  ADDR_WIDTH  binary write address to memory (low bits of binary pointer)
- w_clken  out  1  memory write enable = W_INC & ~FULL (combinational)
- FULL  out  1  registered full flag
- w_level  out  ADDR_WIDTH+1  pessimistic occupancy, 0..2**ADDR_WIDTH
- w_ovf  out  1  sticky overflow error
- AFULL  out  1  almost-full flag (present only with the optional feature)

Behaviour:
- Reset: binary pointer, w_ptr, FULL, w_level, w_ovf and AFULL are all 0, asserted asynchronously on W_RST rise. Release is synchronous to W_CLK. Reset mid-burst discards the pointer state; no partial write follows.
- State: binary pointer wbin, ADDR_WIDTH+1 bits. Each W_CLK:
  - wbin_next = wbin + (W_INC & ~FULL), wrapping modulo 2**(ADDR_WIDTH+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- w_ptr: registered wgray_next, so it changes in the cycle after an accepted write. Exactly one bit toggles per accepted write, including on wrap 1111→0000 (Gray 1000→0000).
- w_addr: wbin[ADDR_WIDTH-1:0], i.e. the address of the current write slot. Memory writes at w_addr on the W_CLK edge where w_clken=1.
- FULL: registered. Next value is (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}).
  - Asserts in the same edge that accepts the last free slot.
  - Deasserts no earlier than 1 cycle after a wq2_rptr change, giving a pessimistic release; this latency is inherent to the synchronizer.
- w_level: registered. Computed as wbin_next - gray2bin(wq2_rptr), modulo 2**(ADDR_WIDTH+1). Equals 2**ADDR_WIDTH exactly when FULL=1.
- W_INC while FULL=1: write ignored; pointers, level and address hold; w_ovf sets on the next edge and stays set until W_RST.
- W_INC with a simultaneous wq2_rptr advance while FULL=1: write is still rejected in that cycle. FULL clears on the next edge and a retried write is accepted then.
- No empty detection here; that belongs to the read side.

Optional Feature:
- Macro FIFO_WR_AFULL_EN.
- Defined:
  - AFULL port exists, registered.
  - AFULL next = (wbin_next - gray2bin(wq2_rptr)) >= AFULL_THRESH.
  - Reset 0.
- Undefined: AFULL port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam-style constants FIFO_PTR_W = ADDR_WIDTH+1 and FIFO_DEPTH.
  - Functions bin2gray and gray2bin, which are reused by the read-side controller.
- One sub-module is natural: gray2bin_conv, a combinational XOR-prefix converter of width ADDR_WIDTH+1, shared with the read-empty block.

Test Plan:
- Reset: assert W_RST mid-stream with wbin=5 → w_ptr=0000, w_addr=000, FULL=0, w_level=0, w_ovf=0 immediately, without a clock.
- Fill: wq2_rptr held at 0000, W_INC=1 for 8 cycles → w_addr steps 0..7, w_ptr goes 0001,0011,0010,0110,0111,0101,0100,1100, FULL=1 after the 8th edge, w_level=8.
- Overflow: at FULL=1, W_INC=1 for 2 cycles → w_clken=0, w_ptr stays 1100, w_ovf=1 from the next edge and sticky.
- Release: from full, drive wq2_rptr=0001 → FULL=0 and w_level=7 one edge later; next write accepted at w_addr=000, w_ptr=1101.
- Wrap: run 20 writes interleaved with read-pointer advances (rptr trailing by 3) → FULL stays 0, w_level=3 steady, each w_ptr step has Hamming distance 1 including the 1000→0000 wrap.
- AFULL (FIFO_WR_AFULL_EN, AFULL_THRESH=6): from empty, write 5 → AFULL=0; 6th write → AFULL=1; drive wq2_rptr=0001 → AFULL=0.
